// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional feature macro used by this slice: IFETCH_MISALIGN_CHECK_EN
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered instruction as seen by decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO used both for buffered instructions and for the
// addresses of in-flight memory requests. Flush has priority over push/pop.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop  && (count != '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy update; flush empties the FIFO regardless of push/pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; validity is tracked by count alone.
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tracks in-flight
// requests, buffers responses for decode, and handles redirects by
// flushing buffered entries and discarding outstanding responses.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (misaligned redirect
// produces a fault-marker entry and halts fetch until the next redirect).
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4,
    output logic        out_misalign
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    fetch_state_t       state, state_next;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    halt_pc;
    logic [XLEN-1:0]    redirect_pc_eff;
    logic [XLEN-1:0]    addr_head;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   inflight_after;
    logic [CNT_W-1:0]   drop;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic [ENTRY_W-1:0] entry_dout;
    fetch_entry_t       entry_din;
    fetch_entry_t       head;
    logic               has_room;
    logic               req_hs;
    logic               rsp_keep;
    logic               misalign_redirect;
    logic               marker_pending;
    logic               marker_push;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign misalign_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_pc_eff   = redirect_pc;
`else
    assign misalign_redirect = 1'b0;
    assign redirect_pc_eff   = redirect_pc & ~32'h3;
`endif

    // Dropped requests still occupy capacity until their response returns.
    assign occupancy      = {1'b0, inflight} + {1'b0, fifo_count};
    assign has_room       = occupancy < DEPTH_C;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign inflight_after = inflight + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
    assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_next;
    end

    // Next-state and request/marker outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next     = state;
        imem_req_valid = 1'b0;
        marker_push    = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req_valid = has_room && !rst;
                if (misalign_redirect) state_next = ST_HALT;
            end
            ST_HALT: begin
                // The marker goes in only after every dropped response has drained.
                marker_push = marker_pending && (drop == '0) && !redirect_valid;
                if (redirect_valid && !misalign_redirect) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // Fetch address and drop counter; a redirect drops everything still outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc_eff;
            drop     <= inflight_after;
        end else begin
            if (req_hs) fetch_pc <= fetch_pc + 32'd4;
            if (imem_rsp_valid && (drop != '0)) drop <= drop - CNT_W'(1);
        end
    end

    // Pending fault marker for a misaligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            marker_pending <= 1'b0;
            halt_pc        <= '0;
        end else if (redirect_valid) begin
            marker_pending <= misalign_redirect;
            halt_pc        <= redirect_pc_eff;
        end else if (marker_push) begin
            marker_pending <= 1'b0;
        end
    end

    // Entry to enqueue: either a kept memory response or the fault marker.
    always_comb begin
        entry_din = '{pc: addr_head, instr: imem_rsp_data, misalign: 1'b0};
        if (marker_push) entry_din = '{pc: halt_pc, instr: NOP_INSTR, misalign: 1'b1};
    end

    // Addresses of accepted requests, popped as responses return in order.
    ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (req_hs),
        .din   (fetch_pc),
        .pop   (imem_rsp_valid),
        .dout  (addr_head),
        .count (inflight)
    );

    // Instructions waiting for decode.
    ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_entry_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (rsp_keep || marker_push),
        .din   (entry_din),
        .pop   (out_valid && out_ready),
        .dout  (entry_dout),
        .count (fifo_count)
    );

    assign head         = fetch_entry_t'(entry_dout);
    assign out_valid    = (fifo_count != '0);
    assign out_pc       = out_valid ? head.pc : '0;
    assign out_instr    = out_valid ? head.instr : '0;
    assign out_misalign = out_valid && head.misalign;
    assign out_pc_plus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed sequences, a table of
// redirect targets, and randomized traffic against a stream-level model.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic        out_misalign;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_pc_plus4   (out_pc_plus4),
        .out_misalign   (out_misalign)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs (percent probabilities) and pending redirect.
    int          p_ready  = 100;
    int          p_rsp    = 100;
    int          p_oready = 100;
    bit          do_redirect = 1'b0;
    logic [31:0] redirect_target = '0;

    // Memory and stream model.
    logic [31:0] pend_q[$];
    logic [31:0] hs_addr_q[$];
    int          hs_count = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = '0;
    bit          seg_first = 1'b1;
    logic [31:0] seg_first_pc = '0;
    bit          exp_halt = 1'b0;
    bit          exp_marker = 1'b0;
    logic [31:0] marker_pc = '0;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_plus4;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit chance(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // Delivered stream: contiguous words from the last redirect target.
    task automatic model_pop();
        delivered++;
        if (exp_halt) begin
            if (exp_marker) begin
                check("marker_pc", out_pc, marker_pc);
                check("marker_instr", out_instr, NOP_INSTR);
                check("marker_flag", {31'b0, out_misalign}, 32'd1);
                exp_marker = 1'b0;
            end else begin
                check("pop_while_halted", {31'b0, out_valid}, 32'd0);
            end
            return;
        end
        check("out_pc", out_pc, exp_pc);
        check("out_instr", out_instr, mem_word(out_pc));
        check("out_pc_plus4", out_pc_plus4, out_pc + 32'd4);
        check("out_misalign", {31'b0, out_misalign}, 32'd0);
        if (seg_first) begin
            seg_first_pc = out_pc;
            seg_first = 1'b0;
        end
        exp_pc = out_pc + 32'd4;
    endtask

    task automatic model_redirect(input logic [31:0] t);
        seg_first = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            exp_halt = 1'b1;
            exp_marker = 1'b1;
            marker_pc = t;
            return;
        end
`endif
        exp_halt = 1'b0;
        exp_marker = 1'b0;
        exp_pc = t & ~32'h3;
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic tick();
        bit hs;
        bit pop;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend_q.size() > 0 && chance(p_rsp)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q.pop_front());
        end
        imem_req_ready = chance(p_ready);
        out_ready      = chance(p_oready);
        redirect_valid = do_redirect;
        redirect_pc    = redirect_target;
        do_redirect    = 1'b0;
        #1;
        hs = imem_req_valid && imem_req_ready;
        if (hs) begin
            pend_q.push_back(imem_req_addr);
            hs_addr_q.push_back(imem_req_addr);
            hs_count++;
        end
        pop = out_valid && out_ready;
        if (pop) model_pop();
        if (redirect_valid) model_redirect(redirect_pc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc_plus4", out_pc_plus4, 32'd4);
        check("rst_out_misalign", {31'b0, out_misalign}, 32'd0);
        rst = 1'b0;
        pend_q.delete();
        hs_addr_q.delete();
        hs_count = 0;
        delivered = 0;
        exp_pc = 32'h0;
        seg_first = 1'b1;
        exp_halt = 1'b0;
        exp_marker = 1'b0;
    endtask

    task automatic run_until_delivered(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (delivered < n && k < budget) begin
            tick();
            k++;
        end
        check({name, "_timeout"}, {31'b0, delivered >= n}, 32'd1);
    endtask

    initial begin
        vec_t vecs[$];
        int   snap;
        int   k;

        vecs.push_back('{32'h0000_0100, 32'h0000_0100, 32'h0000_0104});
        vecs.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_0004});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'h8000_0004});
        vecs.push_back('{32'h7FFF_FFF8, 32'h7FFF_FFF8, 32'h7FFF_FFFC});
`ifndef IFETCH_MISALIGN_CHECK_EN
        vecs.push_back('{32'h0000_0103, 32'h0000_0100, 32'h0000_0104});
`endif

        @(negedge clk);

        // Sequential fetch with latency-1 memory and free-flowing decode.
        do_reset();
        p_ready = 100; p_rsp = 100; p_oready = 100;
        run_until_delivered(4, 40, "seq_fetch");
        check("seq_first_pc", seg_first_pc, 32'h0);
        check("seq_first_req_addr", hs_addr_q.size() > 0 ? hs_addr_q[0] : 32'hDEAD_BEEF, 32'h0);

        // Capacity limit with decode stalled.
        do_reset();
        p_ready = 100; p_rsp = 100; p_oready = 0;
        for (int i = 0; i < 20; i++) tick();
        check("cap_requests", hs_count, DEPTH);
        check("cap_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
        p_oready = 100;
        tick();
        p_oready = 0;
        check("cap_req_valid_after_pop", {31'b0, imem_req_valid}, 32'd1);

        // Three requests in flight, then redirect: all three discarded.
        do_reset();
        p_ready = 100; p_rsp = 0; p_oready = 100;
        k = 0;
        while (hs_count < 3 && k < 20) begin tick(); k++; end
        p_ready = 0;
        check("inflight3_requests", hs_count, 3);
        tick(); tick();
        check("inflight3_none_delivered", delivered, 0);
        do_redirect = 1'b1; redirect_target = 32'h0000_0100;
        tick();
        p_rsp = 100; p_ready = 100;
        run_until_delivered(3, 60, "inflight3");
        check("inflight3_first_pc", seg_first_pc, 32'h0000_0100);

        // Address wrap at the top of the space.
        do_reset();
        p_ready = 100; p_rsp = 100; p_oready = 0;
        tick(); tick();
        do_redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        hs_addr_q.delete();
        for (int i = 0; i < 4; i++) tick();
        check("wrap_req0", hs_addr_q.size() > 0 ? hs_addr_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_req1", hs_addr_q.size() > 1 ? hs_addr_q[1] : 32'hDEAD_BEEF, 32'h0000_0000);
        p_oready = 100;
        snap = delivered;
        run_until_delivered(snap + 2, 20, "wrap_drain");

        // Table of redirect targets: first entry after each redirect.
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            p_ready = 100; p_rsp = 100; p_oready = 0;
            do_redirect = 1'b1; redirect_target = vecs[i].target;
            tick();
            k = 0;
            while (!out_valid && k < 20) begin tick(); k++; end
            check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_plus4", i), out_pc_plus4, vecs[i].exp_plus4);
            check($sformatf("vec%0d_instr", i), out_instr, mem_word(vecs[i].exp_pc));
            check($sformatf("vec%0d_misalign", i), {31'b0, out_misalign}, 32'd0);
        end

`ifdef IFETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: one marker, no requests, then resume.
        do_reset();
        p_ready = 100; p_rsp = 100; p_oready = 100;
        for (int i = 0; i < 5; i++) tick();
        do_redirect = 1'b1; redirect_target = 32'h0000_0102;
        tick();
        snap = hs_count;
        for (int i = 0; i < 15; i++) tick();
        check("halt_no_requests", hs_count, snap);
        check("halt_marker_delivered", {31'b0, exp_marker}, 32'd0);
        do_redirect = 1'b1; redirect_target = 32'h0000_0200;
        tick();
        snap = delivered;
        run_until_delivered(snap + 2, 40, "halt_resume");
        check("halt_resume_pc", seg_first_pc, 32'h0000_0200);
`endif

        // Randomized traffic with redirects, often coinciding with a pop.
        do_reset();
        p_ready = 50; p_rsp = 60; p_oready = 70;
        for (int i = 0; i < 3000; i++) begin
            if (chance(4) || (out_valid && chance(8))) begin
                do_redirect = 1'b1;
                redirect_target = chance(15) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
`ifdef IFETCH_MISALIGN_CHECK_EN
                if (!chance(10)) redirect_target = redirect_target & ~32'h3;
`endif
            end
            tick();
        end
        check("rand_liveness", {31'b0, delivered > 200}, 32'd1);
        p_ready = 100; p_rsp = 100; p_oready = 100;
        do_redirect = 1'b1; redirect_target = 32'h0000_4000;
        tick();
        snap = delivered;
        run_until_delivered(snap + 8, 80, "rand_drain");
        check("rand_drain_first_pc", seg_first_pc, 32'h0000_4000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
